// File: rtl/png_pkg.sv
`default_nettype none
// ============================================================================
// Module      : png_pkg
// Description : Shared CRC-32 constants, byte-update function, chunk-checker
//               FSM state encoding and error-bit indices for the PNG path.
// Revision    : 1.0 - initial release
// ============================================================================
package png_pkg;

  // Reflected CRC-32 (IEEE 802.3 / zlib) parameters
  localparam logic [31:0] CRC32_POLY_R = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOR    = 32'hFFFF_FFFF;

  // Bit positions inside the {len_err, frame_err, crc_err} error vector
  localparam int ERR_LEN   = 2;
  localparam int ERR_FRAME = 1;
  localparam int ERR_CRC   = 0;

  // Chunk checker FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_TYP  = 3'd2,
    ST_DAT  = 3'd3,
    ST_CRC  = 3'd4,
    ST_DONE = 3'd5
  } chk_state_t;

  // Fold one byte into a reflected CRC-32, LSB of the byte first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data_byte);
    logic [31:0] c;
    c = crc ^ {24'h0, data_byte};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_word_upd.sv
`default_nettype none
// ============================================================================
// Module      : crc32_word_upd
// Description : Combinational CRC-32 update over the leading nbytes bytes of
//               a big-endian 32-bit word; trailing bytes leave CRC untouched.
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_word_upd
  import png_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] dat,
  input  logic [2:0]  nbytes,
  output logic [31:0] crc_out
);

  logic [7:0] w_byte [4];

  // Split the word so byte 0 is the one in [31:24]
  always_comb begin
    w_byte[0] = dat[31:24];
    w_byte[1] = dat[23:16];
    w_byte[2] = dat[15:8];
    w_byte[3] = dat[7:0];
  end

  // Four-byte unrolled chain, each stage gated by the byte count
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes) begin
        crc_out = crc32_byte(crc_out, w_byte[i]);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/png_chunk_chk.sv
`default_nettype none
// ============================================================================
// Module      : png_chunk_chk
// Description : PNG chunk receiver. Parses length/type/payload/CRC words,
//               forwards payload with byte enables, recomputes CRC-32 over
//               type+payload and reports CRC, framing and length errors.
// Revision    : 1.0 - initial release
// ============================================================================
module png_chunk_chk
  import png_pkg::*;
#(
  parameter int          DATA_WD = 32,
  parameter logic [31:0] LEN_MAX = 32'h7FFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               val_i,
  input  logic [DATA_WD-1:0] dat_i,
  input  logic               lst_i,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic [3:0]         be_o,
  output logic [DATA_WD-1:0] typ_o,
  output logic [DATA_WD-1:0] len_o,
  output logic               done_o,
  output logic               ok_o,
  output logic [2:0]         err_o,
  output logic [DATA_WD-1:0] crc_o
);

  chk_state_t  r_state;
  chk_state_t  w_next;

  logic [31:0] r_crc;
  logic [31:0] r_rem;        // payload words still expected
  logic        r_len_err;
  logic [31:0] r_typ;
  logic [31:0] r_len;
  logic        r_val;
  logic [31:0] r_dat;
  logic [3:0]  r_be;
  logic        r_ok;
  logic [2:0]  r_err;
  logic [31:0] r_crc_out;

  logic        w_take;
  logic        w_body;       // state expects a non-CRC word
  logic        w_crc_word;   // accepted word is being treated as the CRC
  logic        w_frame;
  logic        w_crc_bad;
  logic        w_last;
  logic [2:0]  w_last_nb;
  logic [2:0]  w_nbytes;
  logic [3:0]  w_be;
  logic [31:0] w_word_nw;
  logic [31:0] w_crc_upd;
  logic [31:0] w_crc_final;

  // start_i always wins over a word presented in the same cycle
  assign w_take      = val_i && !start_i;
  assign w_body      = (r_state == ST_LEN) || (r_state == ST_TYP) || (r_state == ST_DAT);
  assign w_crc_word  = w_take && ((r_state == ST_CRC) || (w_body && lst_i));
  assign w_frame     = (w_body && lst_i) || ((r_state == ST_CRC) && !lst_i);
  assign w_crc_final = r_crc ^ CRC32_XOR;
  assign w_crc_bad   = (dat_i != w_crc_final);
  assign w_last      = (r_rem == 32'd1);
  assign w_last_nb   = (r_len[1:0] == 2'b00) ? 3'd4 : {1'b0, r_len[1:0]};
  // ceil(len/4) without a 33-bit intermediate
  assign w_word_nw   = {2'b00, dat_i[31:2]} + {31'h0, |dat_i[1:0]};

  // Byte count presented to the CRC unroll for the current word
  always_comb begin
    w_nbytes = 3'd0;
    if (r_state == ST_TYP) begin
      w_nbytes = 3'd4;
    end else if (r_state == ST_DAT) begin
      w_nbytes = w_last ? w_last_nb : 3'd4;
    end
  end

  // MSB-aligned byte enables for the forwarded payload word
  always_comb begin
    case (w_nbytes)
      3'd1:    w_be = 4'b1000;
      3'd2:    w_be = 4'b1100;
      3'd3:    w_be = 4'b1110;
      default: w_be = 4'b1111;
    endcase
  end

  crc32_word_upd u_crc_upd (
    .crc_in  (r_crc),
    .dat     (dat_i),
    .nbytes  (w_nbytes),
    .crc_out (w_crc_upd)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state and done strobe
  always_comb begin
    w_next = r_state;
    done_o = 1'b0;
    if (start_i) begin
      w_next = ST_LEN;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_IDLE;
        ST_LEN: begin
          if (val_i) w_next = lst_i ? ST_DONE : ST_TYP;
        end
        ST_TYP: begin
          if (val_i) begin
            if (lst_i)                               w_next = ST_DONE;
            else if (r_len_err || (r_rem == 32'd0))  w_next = ST_CRC;
            else                                     w_next = ST_DAT;
          end
        end
        ST_DAT: begin
          if (val_i) begin
            if (lst_i)       w_next = ST_DONE;
            else if (w_last) w_next = ST_CRC;
          end
        end
        ST_CRC: begin
          if (val_i) w_next = ST_DONE;
        end
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
    if (r_state == ST_DONE) begin
      done_o = 1'b1;
    end
  end

  // Datapath: header latches, CRC accumulation, payload and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crc     <= CRC32_INIT;
      r_rem     <= 32'h0;
      r_len_err <= 1'b0;
      r_typ     <= 32'h0;
      r_len     <= 32'h0;
      r_val     <= 1'b0;
      r_dat     <= 32'h0;
      r_be      <= 4'h0;
      r_ok      <= 1'b0;
      r_err     <= 3'b000;
      r_crc_out <= 32'h0;
    end else begin
      // Payload and result registers are single-cycle strobes
      r_val     <= 1'b0;
      r_ok      <= 1'b0;
      r_err     <= 3'b000;
      r_crc_out <= 32'h0;
      if (start_i) begin
        r_crc     <= CRC32_INIT;
        r_rem     <= 32'h0;
        r_len_err <= 1'b0;
        r_typ     <= 32'h0;
        r_len     <= 32'h0;
      end else if (w_crc_word) begin
        r_err[ERR_LEN]   <= r_len_err;
        r_err[ERR_FRAME] <= w_frame;
        r_err[ERR_CRC]   <= w_crc_bad;
        r_ok             <= !r_len_err && !w_frame && !w_crc_bad;
        r_crc_out        <= w_crc_final;
      end else if (w_take) begin
        case (r_state)
          ST_LEN: begin
            r_len     <= dat_i;
            r_rem     <= w_word_nw;
            r_len_err <= (dat_i > LEN_MAX);
          end
          ST_TYP: begin
            r_typ <= dat_i;
            r_crc <= w_crc_upd;
          end
          ST_DAT: begin
            r_crc <= w_crc_upd;
            r_rem <= r_rem - 32'd1;
            r_val <= 1'b1;
            r_dat <= dat_i;
            r_be  <= w_be;
          end
          default: ;
        endcase
      end
    end
  end

  assign val_o = r_val;
  assign dat_o = r_dat;
  assign be_o  = r_be;
  assign typ_o = r_typ;
  assign len_o = r_len;
  assign ok_o  = r_ok;
  assign err_o = r_err;
  assign crc_o = r_crc_out;

endmodule
`default_nettype wire

// File: tb/tb_png_chunk_chk.sv
`default_nettype none
// ============================================================================
// Module      : tb_png_chunk_chk
// Description : Self-checking bench for png_chunk_chk: table vectors, random
//               chunks against a table-driven CRC-32 model, and hand-written
//               framing / abort / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_png_chunk_chk;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, val_i, lst_i;
  logic [31:0] dat_i;
  logic        val_o, done_o, ok_o;
  logic [31:0] dat_o, typ_o, len_o, crc_o;
  logic [3:0]  be_o;
  logic [2:0]  err_o;

  always #5 clk = ~clk;

  png_chunk_chk dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .val_i   (val_i),
    .dat_i   (dat_i),
    .lst_i   (lst_i),
    .val_o   (val_o),
    .dat_o   (dat_o),
    .be_o    (be_o),
    .typ_o   (typ_o),
    .len_o   (len_o),
    .done_o  (done_o),
    .ok_o    (ok_o),
    .err_o   (err_o),
    .crc_o   (crc_o)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] crc_tab [256];
  logic [31:0] pl [$];
  logic [31:0] mon_dat [$];
  logic [3:0]  mon_be [$];
  int          done_cnt = 0;
  int          ovl_cnt  = 0;
  logic        d_ok;
  logic [2:0]  d_err;
  logic [31:0] d_crc;

  typedef struct {
    logic [31:0] len;
    logic [31:0] typ;
    logic [31:0] pw0;
    logic [31:0] pw1;
    bit          corrupt;
    bit          exp_ok;
    logic [2:0]  exp_err;
  } vec_t;
  vec_t tbl [6];

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (val_o) begin
      mon_dat.push_back(dat_o);
      mon_be.push_back(be_o);
    end
    if (done_o) begin
      done_cnt++;
      d_ok  = ok_o;
      d_err = err_o;
      d_crc = crc_o;
      if (val_o) ovl_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // zlib-style byte-table CRC over type bytes then the first len payload bytes
  function automatic logic [31:0] ref_crc(input logic [31:0] typ, input int len);
    logic [31:0] c;
    logic [31:0] wd;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      b = typ[31-8*k -: 8];
      c = crc_tab[c[7:0] ^ b] ^ (c >> 8);
    end
    for (int k = 0; k < len; k++) begin
      wd = pl[k/4];
      b  = wd[31-8*(k%4) -: 8];
      c  = crc_tab[c[7:0] ^ b] ^ (c >> 8);
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_dat.delete();
    mon_be.delete();
    done_cnt = 0;
    ovl_cnt  = 0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    val_i = 1'b1;
    dat_i = d;
    lst_i = l;
    tick();
    val_i = 1'b0;
    lst_i = 1'b0;
    dat_i = $urandom;
  endtask

  // Wait (bounded) for a done pulse, then let a couple of cycles drain
  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick();
      k++;
    end
    tick();
    tick();
  endtask

  // Send a well-formed chunk using pl as payload and check everything
  task automatic run_chunk(input string nm, input int len, input logic [31:0] typ,
                           input bit corrupt, input bit exp_ok, input logic [2:0] exp_err);
    int          nw;
    int          rem;
    logic [31:0] exp_crc;
    logic [31:0] crc_w;
    logic [7:0]  t;
    logic [3:0]  eb;
    logic [31:0] m;
    nw      = (len + 3) / 4;
    rem     = (len % 4 == 0) ? 4 : len % 4;
    exp_crc = ref_crc(typ, len);
    crc_w   = corrupt ? (exp_crc ^ (32'h1 << $urandom_range(31, 0))) : exp_crc;
    clear_mon();
    pulse_start();
    send(32'(len), 1'b0);
    send(typ, 1'b0);
    for (int i = 0; i < nw; i++) send(pl[i], 1'b0);
    send(crc_w, 1'b1);
    wait_done(8);
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_ok"}, {31'h0, d_ok}, {31'h0, exp_ok});
    chk({nm, "_err"}, {29'h0, d_err}, {29'h0, exp_err});
    chk({nm, "_crc"}, d_crc, exp_crc);
    chk({nm, "_ovl"}, ovl_cnt, 0);
    chk({nm, "_typ"}, typ_o, typ);
    chk({nm, "_len"}, len_o, 32'(len));
    chk({nm, "_nval"}, mon_dat.size(), nw);
    for (int i = 0; i < nw && i < mon_dat.size(); i++) begin
      if (i == nw - 1) begin
        t  = 8'hF0 >> rem;
        eb = t[3:0];
      end else begin
        eb = 4'hF;
      end
      m = {{8{eb[3]}}, {8{eb[2]}}, {8{eb[1]}}, {8{eb[0]}}};
      chk({nm, "_be"}, {28'h0, mon_be[i]}, {28'h0, eb});
      chk({nm, "_dat"}, mon_dat[i] & m, pl[i] & m);
    end
  endtask

  initial begin
    logic [31:0] c;
    int          len;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end

    tbl[0] = '{32'd0,  32'h4945_4E44, 32'h0,         32'h0,         1'b0, 1'b1, 3'b000};
    tbl[1] = '{32'd5,  32'h7445_5874, 32'h4142_4344, 32'h4500_0000, 1'b0, 1'b1, 3'b000};
    tbl[2] = '{32'd1,  32'h4944_4154, 32'h7800_0000, 32'h0,         1'b1, 1'b0, 3'b001};
    tbl[3] = '{32'd4,  32'h6348_524D, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 3'b000};
    tbl[4] = '{32'd7,  32'h7048_5973, 32'h0102_0304, 32'h0506_0708, 1'b0, 1'b1, 3'b000};
    tbl[5] = '{32'd12, 32'h4944_4154, 32'hCAFE_F00D, 32'h1234_5678, 1'b1, 1'b0, 3'b001};

    rst = 1'b1; start_i = 1'b0; val_i = 1'b0; lst_i = 1'b0; dat_i = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {28'h0, val_o, done_o, ok_o, |err_o}, 32'h0);
    chk("rst_crc", crc_o, 32'h0);
    chk("rst_typ_len", typ_o | len_o, 32'h0);
    chk("rst_dat_be", dat_o | {28'h0, be_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      pl.delete();
      pl.push_back(tbl[v].pw0);
      pl.push_back(tbl[v].pw1);
      pl.push_back($urandom);
      run_chunk($sformatf("tbl%0d", v), int'(tbl[v].len), tbl[v].typ,
                tbl[v].corrupt, tbl[v].exp_ok, tbl[v].exp_err);
    end

    // IEND with the known CRC constant, good and bad
    clear_mon(); pulse_start();
    send(32'h0, 1'b0); send(32'h4945_4E44, 1'b0); send(32'hAE42_6082, 1'b1);
    wait_done(8);
    chk("iend_done", done_cnt, 1);
    chk("iend_ok_err", {28'h0, d_ok, d_err}, 32'h8);
    chk("iend_crc", d_crc, 32'hAE42_6082);
    chk("iend_nval", mon_dat.size(), 0);

    clear_mon(); pulse_start();
    send(32'h0, 1'b0); send(32'h4945_4E44, 1'b0); send(32'hAE42_6083, 1'b1);
    wait_done(8);
    chk("iendbad_done", done_cnt, 1);
    chk("iendbad_ok_err", {28'h0, d_ok, d_err}, 32'h1);
    chk("iendbad_crc", d_crc, 32'hAE42_6082);

    // CRC word without lst_i: framing error, CRC still compared
    clear_mon(); pulse_start();
    send(32'h0, 1'b0); send(32'h4945_4E44, 1'b0); send(32'hAE42_6082, 1'b0);
    wait_done(8);
    chk("nolst_done", done_cnt, 1);
    chk("nolst_ok_err", {28'h0, d_ok, d_err}, 32'h2);

    // Early lst_i on the 2nd payload word of an 8-byte chunk
    clear_mon(); pulse_start();
    send(32'd8, 1'b0); send(32'h4944_4154, 1'b0);
    send(32'h1111_2222, 1'b0); send(32'h3333_4444, 1'b1);
    wait_done(8);
    chk("early_done", done_cnt, 1);
    chk("early_frame", {31'h0, d_err[1]}, 32'h1);
    chk("early_ok", {31'h0, d_ok}, 32'h0);
    chk("early_nval", mon_dat.size(), 1);
    // Idle afterwards: words without start_i are ignored
    clear_mon();
    send($urandom, 1'b0); send($urandom, 1'b1);
    repeat (3) tick();
    chk("idle_ignore", done_cnt + mon_dat.size(), 0);

    // Oversize length: no payload, next word after TYP is the CRC word
    clear_mon(); pulse_start();
    send(32'h8000_0000, 1'b0); send(32'h4944_4154, 1'b0); send(32'h5555_AAAA, 1'b1);
    wait_done(8);
    chk("lenerr_done", done_cnt, 1);
    chk("lenerr_bits", {30'h0, d_err[2:1]}, 32'h2);
    chk("lenerr_ok", {31'h0, d_ok}, 32'h0);
    chk("lenerr_nval", mon_dat.size(), 0);
    chk("lenerr_len", len_o, 32'h8000_0000);

    // Restart mid-payload (with a colliding word), then a full IEND
    clear_mon(); pulse_start();
    send(32'd12, 1'b0); send(32'h4944_4154, 1'b0);
    send(32'h0102_0304, 1'b0); send(32'h0506_0708, 1'b0);
    val_i = 1'b1; dat_i = 32'hFFFF_FFFF; lst_i = 1'b1;
    pulse_start();
    val_i = 1'b0; lst_i = 1'b0;
    clear_mon();
    send(32'h0, 1'b0); send(32'h4945_4E44, 1'b0); send(32'hAE42_6082, 1'b1);
    wait_done(8);
    chk("abort_done", done_cnt, 1);
    chk("abort_ok", {31'h0, d_ok}, 32'h1);
    chk("abort_nval", mon_dat.size(), 0);

    // Reset mid-chunk: no done, remaining words ignored
    clear_mon(); pulse_start();
    send(32'd8, 1'b0); send(32'h4944_4154, 1'b0); send(32'h0A0B_0C0D, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out", {28'h0, val_o, done_o, ok_o, |err_o} | len_o | typ_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_mon();
    send(32'h0E0F_1011, 1'b0); send(32'h1234_5678, 1'b1);
    repeat (3) tick();
    chk("midrst_quiet", done_cnt + mon_dat.size(), 0);

    // Random chunks against the reference model
    for (int r = 0; r < 12; r++) begin
      bit cor;
      len = $urandom_range(0, 24);
      cor = 1'($urandom_range(0, 1));
      pl.delete();
      for (int i = 0; i < 7; i++) pl.push_back($urandom);
      run_chunk($sformatf("rnd%0d", r), len, $urandom, cor, !cor, cor ? 3'b001 : 3'b000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
